// File: rtl/mips_pkg.sv
// Shared MIPS definitions: primary opcodes, datapath width and the
// encoding of the instruction-fetch state machine.
package mips_pkg;

  localparam int XLEN = 32;

  // Primary opcode field values (instr[31:26])
  localparam logic [5:0] OP_RTYPE = 6'h00;
  localparam logic [5:0] OP_LW    = 6'h23;
  localparam logic [5:0] OP_SW    = 6'h2B;
  localparam logic [5:0] OP_BEQ   = 6'h04;

  // Fetch FSM encoding (binary)
  typedef logic [1:0] fetch_state_t;
  localparam logic [1:0] S_FETCH = 2'd0;
  localparam logic [1:0] S_WAIT  = 2'd1;
  localparam logic [1:0] S_HOLD  = 2'd2;

endpackage

// File: rtl/pc_next.sv
// Next-PC selection: sequential pc+4 or BEQ target
// pc + 4 + (sext(imm16) << 2). All sums are modulo 2^32, so the
// top of the address space wraps to zero.
module pc_next
  import mips_pkg::*;
(
  input  logic [XLEN-1:0] pc,
  input  logic [15:0]     imm16,
  input  logic            taken,
  output logic [XLEN-1:0] next_pc
);

  logic [XLEN-1:0] seq_pc;
  logic [XLEN-1:0] offset;

  // Sequential address, sign-extended word offset and final select
  always_comb begin
    seq_pc  = pc + 32'd4;
    offset  = {{14{imm16[15]}}, imm16, 2'b00};
    next_pc = taken ? (seq_pc + offset) : seq_pc;
  end

endmodule

// File: rtl/instr_fetch.sv
// Instruction fetch unit: FETCH issues a one-cycle imem_req for pc,
// WAIT captures the memory response, HOLD presents the instruction
// until downstream accepts it, then pc advances (or branches on a
// taken BEQ) and the next fetch starts.
// Optional build macro: IFETCH_PERF_EN adds stall_cnt[15:0], a
// saturating count of cycles spent waiting on instruction memory.
// fsm_state exposes the current FSM state for observation.
module instr_fetch
  import mips_pkg::*;
#(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic         clk,
  input  logic         rst_n,
  output logic         imem_req,
  output logic [31:0]  imem_addr,
  input  logic         imem_rvalid,
  input  logic [31:0]  imem_rdata,
  output logic         instr_valid,
  input  logic         instr_ready,
  output logic [31:0]  instr,
  output logic [5:0]   opcode,
  output logic [5:0]   func,
  output logic [31:0]  pc,
  input  logic         branch,
  input  logic         Zero,
`ifdef IFETCH_PERF_EN
  output logic [15:0]  stall_cnt,
`endif
  output fetch_state_t fsm_state
);

  // Handshake: an instruction transfers on any cycle where
  // instr_valid & instr_ready are both high. Once instr_valid rises it
  // stays high with instr/pc unchanged until that transfer happens.
  // branch/Zero are only meaningful on the transfer cycle.

  fetch_state_t    state;
  logic            armed;
  logic            accept;
  logic            taken;
  logic [XLEN-1:0] pc_nxt;

  assign accept = (state == S_HOLD) & instr_ready;
  assign taken  = branch & Zero;

  pc_next u_pc_next (
    .pc      (pc),
    .imm16   (instr[15:0]),
    .taken   (taken),
    .next_pc (pc_nxt)
  );

  // armed holds off the very first request until one clock edge has
  // passed after reset release, so imem_req is low throughout reset.
  // FSM, pc and instruction register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= S_FETCH;
      armed <= 1'b0;
      pc    <= {RESET_PC[31:2], 2'b00};
      instr <= 32'h0;
    end else begin
      armed <= 1'b1;
      case (state)
        S_FETCH: begin
          if (armed) state <= S_WAIT;
        end
        S_WAIT: begin
          if (imem_rvalid) begin
            instr <= imem_rdata;
            state <= S_HOLD;
          end
        end
        S_HOLD: begin
          if (accept) begin
            pc    <= pc_nxt;
            state <= S_FETCH;
          end
        end
        default: state <= S_FETCH;
      endcase
    end
  end

  // Outputs decoded from state and the held instruction
  always_comb begin
    imem_req    = (state == S_FETCH) & armed;
    imem_addr   = {pc[31:2], 2'b00};
    instr_valid = (state == S_HOLD);
    opcode      = instr[31:26];
    func        = instr[5:0];
    fsm_state   = state;
  end

`ifdef IFETCH_PERF_EN
  // Memory stall counter: one count per cycle in WAIT, saturating
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stall_cnt <= 16'h0;
    end else if ((state == S_WAIT) && (stall_cnt != 16'hFFFF)) begin
      stall_cnt <= stall_cnt + 16'd1;
    end
  end
`endif

endmodule

// File: tb/tb_instr_fetch.sv
// Directed testbench for instr_fetch: reset values, fetch latency,
// sequential and branch pc updates, HOLD stability, address wrap,
// asynchronous reset mid-fetch and (when built with IFETCH_PERF_EN)
// the stall counter.
module tb_instr_fetch;

  localparam logic [31:0] RPC = 32'h0000_0100;

  // ---------------- clock / reset ----------------
  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  always #5 clk = ~clk;

  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_rvalid = 1'b0;
  logic [31:0] imem_rdata = 32'h0;
  logic        instr_valid;
  logic        instr_ready = 1'b0;
  logic [31:0] instr;
  logic [5:0]  opcode;
  logic [5:0]  func;
  logic [31:0] pc;
  logic        branch = 1'b0;
  logic        zero = 1'b0;
  logic [1:0]  fsm_state;
`ifdef IFETCH_PERF_EN
  logic [15:0] stall_cnt;
`endif

  instr_fetch #(.RESET_PC(RPC)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .imem_req    (imem_req),
    .imem_addr   (imem_addr),
    .imem_rvalid (imem_rvalid),
    .imem_rdata  (imem_rdata),
    .instr_valid (instr_valid),
    .instr_ready (instr_ready),
    .instr       (instr),
    .opcode      (opcode),
    .func        (func),
    .pc          (pc),
    .branch      (branch),
    .Zero        (zero),
`ifdef IFETCH_PERF_EN
    .stall_cnt   (stall_cnt),
`endif
    .fsm_state   (fsm_state)
  );

  // ---------------- scoreboard ----------------
  int          n_vec  = 0;
  int          n_miss = 0;
  logic [31:0] exp_q[$];   // expected pc of each upcoming fetch

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_miss++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // ---------------- driver tasks ----------------
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Called in a cycle where a request should be visible; answers it
  // after lat cycles and checks the held instruction.
  task automatic serve(input logic [31:0] word, input int lat);
    logic [31:0] exp_pc;
    exp_pc = (exp_q.size() != 0) ? exp_q.pop_front() : 32'hxxxx_xxxx;
    check("req", {31'b0, imem_req}, 32'd1);
    check("req_addr", imem_addr, exp_pc);
    tick();
    for (int i = 0; i < lat - 1; i++) begin
      check("wait_req", {31'b0, imem_req}, 32'd0);
      check("wait_valid", {31'b0, instr_valid}, 32'd0);
      tick();
    end
    check("wait_valid", {31'b0, instr_valid}, 32'd0);
    imem_rvalid = 1'b1;
    imem_rdata  = word;
    tick();
    imem_rvalid = 1'b0;
    imem_rdata  = 32'h0;
    check("valid", {31'b0, instr_valid}, 32'd1);
    check("instr", instr, word);
    check("opcode", {26'b0, opcode}, {26'b0, word[31:26]});
    check("func", {26'b0, func}, {26'b0, word[5:0]});
    check("pc", pc, exp_pc);
    check("hold_req", {31'b0, imem_req}, 32'd0);
  endtask

  task automatic accept(input logic br, input logic z, input logic [31:0] exp_next);
    instr_ready = 1'b1;
    branch      = br;
    zero        = z;
    tick();
    instr_ready = 1'b0;
    branch      = 1'b0;
    zero        = 1'b0;
    exp_q.push_back(exp_next);
  endtask

  // ---------------- stimulus ----------------
  initial begin
    logic [31:0] held_instr;
    logic [31:0] held_pc;

    // reset state, sampled while rst_n is low
    repeat (2) @(posedge clk);
    #1;
    check("rst_req", {31'b0, imem_req}, 32'd0);
    check("rst_valid", {31'b0, instr_valid}, 32'd0);
    check("rst_pc", pc, RPC);
    check("rst_instr", instr, 32'h0);
    check("rst_state", {30'b0, fsm_state}, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    tick();   // first edge after release issues the request

    exp_q.push_back(32'h0000_0100);
    serve(32'h012A_4020, 1);             // add $t0,$t1,$t2
    accept(1'b0, 1'b0, 32'h0000_0104);
    serve(32'h8D09_0004, 1);             // lw
    accept(1'b0, 1'b0, 32'h0000_0108);
    serve(32'hAD09_0008, 1);             // sw

    // ready low for 5 cycles; stray response and branch/Zero ignored
    held_instr = 32'hAD09_0008;
    held_pc    = 32'h0000_0108;
    branch = 1'b1;
    zero   = 1'b1;
    for (int i = 0; i < 5; i++) begin
      if (i == 2) begin
        imem_rvalid = 1'b1;
        imem_rdata  = 32'hDEAD_BEEF;
      end
      tick();
      imem_rvalid = 1'b0;
      imem_rdata  = 32'h0;
      check("stall_valid", {31'b0, instr_valid}, 32'd1);
      check("stall_instr", instr, held_instr);
      check("stall_pc", pc, held_pc);
      check("stall_req", {31'b0, imem_req}, 32'd0);
    end
    branch = 1'b0;
    zero   = 1'b0;
    accept(1'b0, 1'b0, 32'h0000_010C);

    // BEQ imm=-1: taken branches to itself, untaken falls through
    serve(32'h1109_FFFF, 1);
    accept(1'b1, 1'b1, 32'h0000_010C);
    serve(32'h1109_FFFF, 1);
    accept(1'b1, 1'b0, 32'h0000_0110);
    // Zero without branch is not taken
    serve(32'h1109_FFBA, 1);
    accept(1'b0, 1'b1, 32'h0000_0114);
    // taken backwards branch to the last word of the address space
    serve(32'h1109_FFB9, 1);
    accept(1'b1, 1'b1, 32'hFFFF_FFFC);
    serve(32'h012A_4020, 1);
    accept(1'b0, 1'b0, 32'h0000_0000);   // pc+4 wraps

    // request at 0, then reset asserted while in WAIT
    check("wrap_req", {31'b0, imem_req}, 32'd1);
    check("wrap_addr", imem_addr, (exp_q.size() != 0) ? exp_q.pop_front() : 32'hxxxx_xxxx);
    tick();
    check("wait_state", {30'b0, fsm_state}, 32'd1);
    #2;
    rst_n = 1'b0;
    #1;
    check("arst_req", {31'b0, imem_req}, 32'd0);
    check("arst_valid", {31'b0, instr_valid}, 32'd0);
    check("arst_pc", pc, RPC);
    check("arst_instr", instr, 32'h0);
    check("arst_state", {30'b0, fsm_state}, 32'd0);
`ifdef IFETCH_PERF_EN
    check("arst_stall_cnt", {16'b0, stall_cnt}, 32'd0);
`endif
    @(negedge clk);
    rst_n = 1'b1;
    tick();

    // 3-cycle memory latency
    exp_q.push_back(32'h0000_0100);
    serve(32'h8D09_0004, 3);
`ifdef IFETCH_PERF_EN
    check("stall_cnt_1", {16'b0, stall_cnt}, 32'd3);
`endif
    accept(1'b0, 1'b0, 32'h0000_0104);
    serve(32'hAD09_0008, 3);
`ifdef IFETCH_PERF_EN
    check("stall_cnt_2", {16'b0, stall_cnt}, 32'd6);
`endif

    // ---------------- final report ----------------
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

  // Watchdog so the run always ends
  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

endmodule
